// File: rtl/uncached_bridge.sv
// Uncached access bridge: accepts one CPU uncached request at a time and
// replays it on an SRAM-like bus (request/addr_ok, then data_ok), returning a
// single-cycle cpu_ack with read data. All outputs decode registered state only.
//
// Handshake summary: cpu_req is held with stable fields until cpu_ack; the
// bridge holds bus_req and all bus fields stable until bus_addr_ok; the
// response is taken on the first bus_data_ok at or after address acceptance;
// data_ok seen in IDLE/RESP, or in ADDR without addr_ok, is dropped.
module uncached_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // CPU side
  input  logic                cpu_req,
  input  logic                cpu_wr,
  input  logic [1:0]          cpu_size,
  input  logic [ADDR_W-1:0]   cpu_paddr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ack,
  output logic                busy,
  // Bus side
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  // Status
  output logic [31:0]         xfer_cnt,
  output logic [1:0]          dbg_state_o
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e              state_q;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [31:0]         cnt_q;

  // Transaction FSM plus request latch, read-data capture and completion counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      paddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            wr_q    <= cpu_wr;
            size_q  <= cpu_size;
            paddr_q <= cpu_paddr;
            wdata_q <= cpu_wdata;
            wstrb_q <= cpu_wstrb;
            // Cleared so a write completes with zero read data
            rdata_q <= '0;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (bus_addr_ok) begin
            if (bus_data_ok) begin
              if (!wr_q) rdata_q <= bus_rdata;
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus_data_ok) begin
            if (!wr_q) rdata_q <= bus_rdata;
            state_q <= RESP;
          end
        end
        RESP: begin
          // 32-bit counter wraps naturally
          cnt_q   <= cnt_q + 32'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state
  always_comb begin
    bus_req     = (state_q == ADDR);
    bus_wr      = wr_q;
    bus_size    = size_q;
    bus_addr    = paddr_q;
    bus_wdata   = wdata_q;
    bus_wstrb   = wr_q ? wstrb_q : '0;
    cpu_ack     = (state_q == RESP);
    cpu_rdata   = (state_q == RESP) ? rdata_q : '0;
    busy        = (state_q != IDLE);
    xfer_cnt    = cnt_q;
    dbg_state_o = state_q;
  end

endmodule
